if_stage: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, drives the fetch address into the instruction memory, selects the next PC (sequential, branch, jump, register jump) from ID-stage control, and holds the IF/ID pipeline register with stall and flush control. Branches use one delay slot: the instruction fetched alongside a resolving branch is always kept.

---
 rtl/if_stage.sv | 88 ++++++++
 tb/tb_if_stage.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory fetch
// address, selects the next PC from ID-stage control and holds the IF/ID
// pipeline register. Branches have one delay slot, and that slot is always kept.
module if_stage #(
  parameter logic [31:0] PC_INIT  = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  npc_sel,
  input  logic [31:0] br_pc,
  input  logic [25:0] br_imm,
  input  logic [31:0] rs_val,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid,
  output logic        if_id_adel
);

  // Last word-aligned address inside the instruction-memory window.
  localparam logic [31:0] PC_LAST = PC_INIT + 32'(4 * IM_WORDS) - 32'd4;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_REG    = 2'b11;

  logic [31:0] pc;
  logic [31:0] target;
  logic [31:0] br_seq;
  logic [31:0] br_off;
  logic        adel_now;

  assign im_pc  = pc;
  assign br_seq = br_pc + 32'd4;
  assign br_off = {{14{br_imm[15]}}, br_imm[15:0], 2'b00};

  // Next-PC selection; all arithmetic wraps modulo 2^32.
  always_comb begin
    target = pc + 32'd4;
    unique case (npc_sel)
      SEL_SEQ:    target = pc + 32'd4;
      SEL_BRANCH: target = br_seq + br_off;
      SEL_JUMP:   target = {br_seq[31:28], br_imm, 2'b00};
      SEL_REG:    target = rs_val;
      default:    target = pc + 32'd4;
    endcase
  end

  // Fetch-address error: misaligned or outside the instruction-memory window.
  always_comb begin
    adel_now = (pc[1:0] != 2'b00) || (pc < PC_INIT) || (pc > PC_LAST);
  end

  // PC register: hold on stall, otherwise advance to the selected target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= PC_INIT;
    end else if (!stall) begin
      pc <= target;
    end
  end

  // IF/ID register: flush beats stall; a faulting fetch carries a nop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id_instr <= 32'd0;
      if_id_pc    <= 32'd0;
      if_id_valid <= 1'b0;
      if_id_adel  <= 1'b0;
    end else if (flush) begin
      if_id_instr <= 32'd0;
      if_id_pc    <= 32'd0;
      if_id_valid <= 1'b0;
      if_id_adel  <= 1'b0;
    end else if (!stall) begin
      if_id_instr <= adel_now ? 32'd0 : im_instr;
      if_id_pc    <= pc;
      if_id_valid <= 1'b1;
      if_id_adel  <= adel_now;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage: sequential fetch, branch/jump/register
// redirects, stall, flush, fetch-address errors and asynchronous reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic [1:0]  npc_sel;
  logic [31:0] br_pc;
  logic [25:0] br_imm;
  logic [31:0] rs_val;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic        if_id_adel;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .npc_sel(npc_sel), .br_pc(br_pc), .br_imm(br_imm), .rs_val(rs_val),
    .im_pc(im_pc), .im_instr(im_instr),
    .if_id_instr(if_id_instr), .if_id_pc(if_id_pc),
    .if_id_valid(if_id_valid), .if_id_adel(if_id_adel)
  );

  always #5 clk = ~clk;

  // Instruction memory model: a distinct, nonzero word for every address.
  function automatic logic [31:0] imw(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign im_instr = imw(im_pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; flush = 1'b0; npc_sel = 2'b00;
    #1;
    chk("rst_pc", im_pc, 32'h3000);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; npc_sel = 2'b00;
    br_pc = 32'd0; br_imm = 26'd0; rs_val = 32'd0;
    #2;
    chk("reset_im_pc", im_pc, 32'h3000);
    chk("reset_instr", if_id_instr, 32'd0);
    chk("reset_if_pc", if_id_pc, 32'd0);
    chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
    chk("reset_adel", {31'd0, if_id_adel}, 32'd0);
    #1 reset = 1'b0;

    // Sequential fetch
    step();
    chk("seq1_im_pc", im_pc, 32'h3004);
    chk("seq1_if_pc", if_id_pc, 32'h3000);
    chk("seq1_instr", if_id_instr, imw(32'h3000));
    chk("seq1_valid", {31'd0, if_id_valid}, 32'd1);
    step();
    chk("seq2_im_pc", im_pc, 32'h3008);
    chk("seq2_if_pc", if_id_pc, 32'h3004);
    step();
    chk("seq3_im_pc", im_pc, 32'h300C);
    chk("seq3_instr", if_id_instr, imw(32'h3008));
    step();
    step();
    chk("seq5_im_pc", im_pc, 32'h3014);

    // Branch backwards with delay slot
    npc_sel = 2'b01; br_pc = 32'h3010; br_imm = 26'h000FFFC;
    step();
    chk("br_im_pc", im_pc, 32'h3004);
    chk("br_slot_pc", if_id_pc, 32'h3014);
    chk("br_slot_instr", if_id_instr, imw(32'h3014));

    // Jump
    npc_sel = 2'b10; br_pc = 32'h3020; br_imm = 26'h0000C40;
    step();
    chk("j_im_pc", im_pc, 32'h0000_3100);
    chk("j_if_pc", if_id_pc, 32'h3004);

    // Register jump
    npc_sel = 2'b11; rs_val = 32'h3400;
    step();
    chk("jr_im_pc", im_pc, 32'h3400);
    chk("jr_if_pc", if_id_pc, 32'h3100);
    npc_sel = 2'b00;

    // Stall with redirect pending
    do_reset();
    step();
    step();
    chk("st0_im_pc", im_pc, 32'h3008);
    stall = 1'b1; npc_sel = 2'b11; rs_val = 32'h3400;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_im_pc", im_pc, 32'h3008);
      chk("st_if_pc", if_id_pc, 32'h3004);
      chk("st_instr", if_id_instr, imw(32'h3004));
      chk("st_valid", {31'd0, if_id_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk("st_rel_im_pc", im_pc, 32'h3400);
    chk("st_rel_if_pc", if_id_pc, 32'h3008);
    npc_sel = 2'b00;

    // Flush together with stall
    do_reset();
    step(); step(); step();
    chk("fl0_im_pc", im_pc, 32'h300C);
    stall = 1'b1; flush = 1'b1;
    step();
    chk("fl_im_pc", im_pc, 32'h300C);
    chk("fl_valid", {31'd0, if_id_valid}, 32'd0);
    chk("fl_instr", if_id_instr, 32'd0);
    chk("fl_if_pc", if_id_pc, 32'd0);
    stall = 1'b0; flush = 1'b0;
    step();
    chk("fl_next_if_pc", if_id_pc, 32'h300C);
    chk("fl_next_valid", {31'd0, if_id_valid}, 32'd1);
    chk("fl_next_im_pc", im_pc, 32'h3010);

    // Misaligned fetch
    npc_sel = 2'b11; rs_val = 32'h3002;
    step();
    chk("mis_im_pc", im_pc, 32'h3002);
    npc_sel = 2'b00;
    step();
    chk("mis_if_pc", if_id_pc, 32'h3002);
    chk("mis_adel", {31'd0, if_id_adel}, 32'd1);
    chk("mis_instr", if_id_instr, 32'd0);
    chk("mis_valid", {31'd0, if_id_valid}, 32'd1);
    chk("mis_im_pc2", im_pc, 32'h3006);

    // Above the window
    npc_sel = 2'b11; rs_val = 32'h7000;
    step();
    npc_sel = 2'b00;
    step();
    chk("hi_if_pc", if_id_pc, 32'h7000);
    chk("hi_adel", {31'd0, if_id_adel}, 32'd1);
    chk("hi_instr", if_id_instr, 32'd0);
    chk("hi_im_pc", im_pc, 32'h7004);

    // Last legal word
    npc_sel = 2'b11; rs_val = 32'h6FFC;
    step();
    npc_sel = 2'b00;
    step();
    chk("last_adel", {31'd0, if_id_adel}, 32'd0);
    chk("last_instr", if_id_instr, imw(32'h6FFC));

    // Below the window
    npc_sel = 2'b11; rs_val = 32'h2FFC;
    step();
    npc_sel = 2'b00;
    step();
    chk("lo_adel", {31'd0, if_id_adel}, 32'd1);
    chk("lo_instr", if_id_instr, 32'd0);

    // Asynchronous reset between edges
    step();
    #2 reset = 1'b1;
    #1;
    chk("arst_im_pc", im_pc, 32'h3000);
    chk("arst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("arst_if_pc", if_id_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();
    chk("arst_after_if_pc", if_id_pc, 32'h3000);
    chk("arst_after_im_pc", im_pc, 32'h3004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
